ram_port_arbiter: RTL and testbench

- Shares the design's single-port synchronous RAM between the RISC processor and a memory-dump sequencer.
- Replaces the static dump/processor address mux with a clocked two-requester arbiter:
  - fixed CPU priority
  - starvation guard for the dump side
  - request/acknowledge handshake for the CPU
  - auto-incrementing dump pointer feeding the display path
- Sits between the processor memory interface, the debounced dump-step input, and the RAM instance.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/ram_port_arbiter_dump_ptr_gen.sv | 58 +++++
 rtl/ram_port_arbiter.sv | 123 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the RAM port arbiter.
// Latency: n/a (declarations only).  Backpressure: n/a.
package mem_arb_pkg;

   localparam int AW_DEF            = 16;
   localparam int DW_DEF            = 16;
   localparam int CPU_BURST_MAX_DEF = 4;

   typedef logic [2:0] arb_state_t;

   localparam arb_state_t ST_IDLE       = 3'd0;
   localparam arb_state_t ST_ISSUE_CPU  = 3'd1;
   localparam arb_state_t ST_RESP_CPU   = 3'd2;
   localparam arb_state_t ST_ISSUE_DUMP = 3'd3;
   localparam arb_state_t ST_RESP_DUMP  = 3'd4;

endpackage

// File: rtl/ram_port_arbiter_dump_ptr_gen.sv
// Dump pointer and pending flag; DUMP_AUTO_EN replaces dump_step with a free-running divider.
// Latency: pend visible the cycle after the step.  Backpressure: steps seen while pending are dropped.
module dump_ptr_gen #(
   parameter int AW       = 16,
   parameter int AUTO_DIV = 1048576
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          dump_en,
   input  logic          dump_step,
   input  logic          dump_done,
   output logic [AW-1:0] dump_ptr,
   output logic          dump_pend
);

   logic set_req;

   if (AUTO_DIV < 1) begin : g_bad_div
      $error("AUTO_DIV must be at least 1");
   end

`ifdef DUMP_AUTO_EN
   localparam int CW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(AUTO_DIV - 1);

   logic [CW-1:0] div_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         div_cnt <= '0;
      else if (!dump_en || div_cnt == DIV_LAST)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   assign set_req = dump_en && (div_cnt == DIV_LAST);
`else
   assign set_req = dump_step;
`endif

   // Disable wins over the completion increment so a re-enable always restarts at 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dump_ptr  <= '0;
         dump_pend <= 1'b0;
      end else if (!dump_en) begin
         dump_ptr  <= '0;
         dump_pend <= 1'b0;
      end else if (dump_done) begin
         dump_ptr  <= dump_ptr + 1'b1;
         dump_pend <= 1'b0;
      end else if (set_req) begin
         dump_pend <= 1'b1;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the single-port RAM: CPU has priority, dump side gets a slot after CPU_BURST_MAX grants (DUMP_AUTO_EN: timed dump steps).
// Latency: cpu_req -> cpu_ack in 2 cycles, dump_step -> dump_valid in 3.  Backpressure: CPU holds cpu_req until cpu_ack; extra dump steps are dropped.
module ram_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW            = AW_DEF,
   parameter int DW            = DW_DEF,
   parameter int CPU_BURST_MAX = CPU_BURST_MAX_DEF,
   parameter int AUTO_DIV      = 1048576
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dump_en,
   input  logic          dump_step,
   output logic [AW-1:0] dump_addr,
   output logic [DW-1:0] dump_data,
   output logic          dump_valid,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);

   localparam int SW = $clog2(CPU_BURST_MAX + 1);
   localparam logic [SW-1:0] STREAK_CAP = SW'(CPU_BURST_MAX);

   if (CPU_BURST_MAX < 1) begin : g_bad_burst
      $error("CPU_BURST_MAX must be at least 1");
   end

   arb_state_t    state;
   arb_state_t    state_nxt;
   logic [AW-1:0] dump_ptr;
   logic          dump_pend;
   logic [AW-1:0] addr_q;
   logic [SW-1:0] streak;
   logic [AW-1:0] dump_addr_q;
   logic [DW-1:0] dump_data_q;
   logic          cpu_win;

   dump_ptr_gen #(
      .AW       (AW),
      .AUTO_DIV (AUTO_DIV)
   ) u_dump_ptr_gen (
      .clk       (clk),
      .reset     (reset),
      .dump_en   (dump_en),
      .dump_step (dump_step),
      .dump_done (state == ST_RESP_DUMP),
      .dump_ptr  (dump_ptr),
      .dump_pend (dump_pend)
   );

   assign cpu_win = cpu_req && (!dump_pend || (streak < STREAK_CAP));

   always_comb begin
      state_nxt = ST_IDLE;
      case (state)
         ST_IDLE: begin
            if (cpu_win)
               state_nxt = ST_ISSUE_CPU;
            else if (dump_pend)
               state_nxt = ST_ISSUE_DUMP;
         end
         ST_ISSUE_CPU:  state_nxt = ST_RESP_CPU;
         ST_ISSUE_DUMP: state_nxt = ST_RESP_DUMP;
         default:       state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Streak only matters while a dump is waiting; it never counts idle-time CPU traffic.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         streak <= '0;
      else if (!dump_pend)
         streak <= '0;
      else if (state == ST_IDLE && state_nxt == ST_ISSUE_DUMP)
         streak <= '0;
      else if (state == ST_IDLE && state_nxt == ST_ISSUE_CPU && streak != STREAK_CAP)
         streak <= streak + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q      <= '0;
         dump_addr_q <= '0;
         dump_data_q <= '0;
      end else begin
         if (state == ST_ISSUE_DUMP)
            addr_q <= dump_ptr;
         if (state == ST_RESP_DUMP) begin
            dump_addr_q <= addr_q;
            dump_data_q <= ram_dout;
         end
      end
   end

   // The RESP_DUMP bypass presents the new word in the same cycle as dump_valid.
   always_comb begin
      ram_we     = (state == ST_ISSUE_CPU) && cpu_we;
      ram_addr   = (state == ST_ISSUE_DUMP) ? dump_ptr : cpu_addr;
      ram_din    = (state == ST_ISSUE_CPU) ? cpu_wdata : '0;
      cpu_ack    = (state == ST_RESP_CPU);
      cpu_rdata  = cpu_ack ? ram_dout : '0;
      dump_valid = (state == ST_RESP_DUMP);
      dump_addr  = dump_valid ? addr_q : dump_addr_q;
      dump_data  = dump_valid ? ram_dout : dump_data_q;
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: a 16-bit-address arbiter for CPU/dump/starvation checks and a 4-bit one for pointer wrap.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int          checks = 0;
   int          errors = 0;

   // 16-bit address instance
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [15:0] cpu_addr = '0, cpu_wdata = '0;
   logic        cpu_ack;
   logic [15:0] cpu_rdata;
   logic        dump_en = 1'b0, dump_step = 1'b0;
   logic [15:0] dump_addr, dump_data;
   logic        dump_valid;
   logic        ram_we;
   logic [15:0] ram_addr, ram_din, ram_dout;
   logic [15:0] mem [0:65535];

   // 4-bit address instance (dump side only)
   logic        cpu_req4 = 1'b0, cpu_we4 = 1'b0;
   logic [3:0]  cpu_addr4 = '0;
   logic [15:0] cpu_wdata4 = '0;
   logic        cpu_ack4;
   logic [15:0] cpu_rdata4;
   logic        dump_en4 = 1'b0, dump_step4 = 1'b0;
   logic [3:0]  dump_addr4;
   logic [15:0] dump_data4;
   logic        dump_valid4;
   logic        ram_we4;
   logic [3:0]  ram_addr4;
   logic [15:0] ram_din4, ram_dout4;
   logic [15:0] mem4 [0:15];

   always #5 clk = ~clk;

   ram_port_arbiter #(.AW(16), .DW(16), .CPU_BURST_MAX(4)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dump_en(dump_en), .dump_step(dump_step),
      .dump_addr(dump_addr), .dump_data(dump_data), .dump_valid(dump_valid),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   ram_port_arbiter #(.AW(4), .DW(16), .CPU_BURST_MAX(4), .AUTO_DIV(8)) u_dut4 (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req4), .cpu_we(cpu_we4), .cpu_addr(cpu_addr4), .cpu_wdata(cpu_wdata4),
      .cpu_ack(cpu_ack4), .cpu_rdata(cpu_rdata4),
      .dump_en(dump_en4), .dump_step(dump_step4),
      .dump_addr(dump_addr4), .dump_data(dump_data4), .dump_valid(dump_valid4),
      .ram_we(ram_we4), .ram_addr(ram_addr4), .ram_din(ram_din4), .ram_dout(ram_dout4)
   );

   // Registered-read RAM models, read-before-write.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   always @(posedge clk) begin
      if (ram_we4) mem4[ram_addr4] <= ram_din4;
      ram_dout4 <= mem4[ram_addr4];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step16();
      dump_step = 1'b1;
      tick();
      dump_step = 1'b0;
   endtask

   initial begin
      int acks;
      int seen;
      for (int i = 0; i < 65536; i++) mem[i] = '0;
      mem[0]     = 16'hA000;
      mem[1]     = 16'hA001;
      mem[16'h0010] = 16'hBEEF;
      for (int i = 0; i < 16; i++) mem4[i] = 16'h4000 + 16'(i);

      // ---- reset, including reset landing in ISSUE_CPU of a write
      repeat (3) tick();
      reset = 1'b0;
      tick();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'h5555;
      tick();
      check("issue_write_we", 32'(ram_we), 32'd1);
      reset = 1'b1;
      #1;
      check("reset_drops_we", 32'(ram_we), 32'd0);
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      tick();
      reset = 1'b0;
      tick();
      check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
      check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      check("rst_dump_valid", 32'(dump_valid), 32'd0);
      check("rst_dump_addr", 32'(dump_addr), 32'd0);
      check("rst_dump_data", 32'(dump_data), 32'd0);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_ram_din", 32'(ram_din), 32'd0);
      check("aborted_write", 32'(mem[16'h0030]), 32'd0);

      // ---- CPU read of 0x0010
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
      tick();
      check("rd_no_ack_n1", 32'(cpu_ack), 32'd0);
      tick();
      check("rd_ack_n2", 32'(cpu_ack), 32'd1);
      check("rd_data", 32'(cpu_rdata), 32'hBEEF);
      cpu_req = 1'b0;
      tick();
      check("rd_ack_pulse", 32'(cpu_ack), 32'd0);

      // ---- CPU write 0x1234 to 0x0020 then read back
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
      tick();
      check("wr_ram_we", 32'(ram_we), 32'd1);
      check("wr_ram_addr", 32'(ram_addr), 32'h0020);
      check("wr_ram_din", 32'(ram_din), 32'h1234);
      tick();
      check("wr_ack", 32'(cpu_ack), 32'd1);
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
      tick();
      cpu_req = 1'b1;
      tick();
      tick();
      check("rb_ack", 32'(cpu_ack), 32'd1);
      check("rb_data", 32'(cpu_rdata), 32'h1234);
      cpu_req = 1'b0;
      tick();

`ifndef DUMP_AUTO_EN
      // ---- two dump steps, 10 cycles apart
      dump_en = 1'b1;
      tick();
      step16();
      tick();
      check("d0_not_early", 32'(dump_valid), 32'd0);
      tick();
      check("d0_valid_n3", 32'(dump_valid), 32'd1);
      check("d0_addr", 32'(dump_addr), 32'h0000);
      check("d0_data", 32'(dump_data), 32'hA000);
      tick();
      check("d0_pulse", 32'(dump_valid), 32'd0);
      check("d0_addr_hold", 32'(dump_addr), 32'h0000);
      repeat (6) tick();
      step16();
      tick();
      tick();
      check("d1_valid", 32'(dump_valid), 32'd1);
      check("d1_addr", 32'(dump_addr), 32'h0001);
      check("d1_data", 32'(dump_data), 32'hA001);
      tick();

      // ---- starvation guard: continuous CPU traffic, one pending dump
      step16();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
      acks = 0; seen = 0;
      for (int c = 0; c < 60 && seen == 0; c++) begin
         tick();
         if (dump_valid) seen = 1;
         else if (cpu_ack) acks++;
      end
      check("starve_dump_seen", 32'(seen), 32'd1);
      check("starve_acks", 32'(acks), 32'd4);
      check("starve_dump_addr", 32'(dump_addr), 32'h0002);
      seen = 0;
      for (int c = 0; c < 10 && seen == 0; c++) begin
         tick();
         if (cpu_ack) seen = 1;
      end
      check("starve_cpu_resumes", 32'(seen), 32'd1);
      cpu_req = 1'b0;
      repeat (3) tick();

      // ---- disable with a step pending behind a CPU access
      cpu_req = 1'b1;
      tick();
      dump_step = 1'b1;
      tick();
      dump_step = 1'b0; cpu_req = 1'b0; dump_en = 1'b0;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (dump_valid) seen++;
      end
      check("dis_no_valid", 32'(seen), 32'd0);
      dump_en = 1'b1;
      tick();
      step16();
      tick();
      tick();
      check("dis_restart_valid", 32'(dump_valid), 32'd1);
      check("dis_restart_addr", 32'(dump_addr), 32'h0000);
      check("dis_restart_data", 32'(dump_data), 32'hA000);
      tick();

      // ---- pointer wrap with AW=4
      dump_en4 = 1'b1;
      tick();
      for (int i = 0; i < 17; i++) begin
         dump_step4 = 1'b1;
         tick();
         dump_step4 = 1'b0;
         tick();
         tick();
         check($sformatf("wrap_valid_%0d", i), 32'(dump_valid4), 32'd1);
         check($sformatf("wrap_addr_%0d", i), 32'(dump_addr4), 32'(i % 16));
         check($sformatf("wrap_data_%0d", i), 32'(dump_data4), 32'h4000 + 32'(i % 16));
         tick();
      end
`else
      // ---- automatic dump steps every AUTO_DIV=8 clocks
      begin
         int last;
         int pulses;
         int cyc;
         last = -1; pulses = 0; cyc = 0;
         dump_en4 = 1'b1;
         for (int c = 0; c < 80 && pulses < 5; c++) begin
            tick();
            cyc++;
            if (dump_valid4) begin
               check($sformatf("auto_addr_%0d", pulses), 32'(dump_addr4), 32'(pulses));
               if (last >= 0)
                  check($sformatf("auto_gap_ok_%0d", pulses),
                        32'((cyc - last) >= 8 && (cyc - last) <= 11), 32'd1);
               last = cyc;
               pulses++;
            end
         end
         check("auto_pulse_count", 32'(pulses), 32'd5);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
